// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between decode/EX and the multiply/divide unit.
//   start, op, rs_data, rt_data, cancel : request side (driven by the master)
//   busy, done, hi, lo                  : status and HI/LO registers (driven by the slave)
interface muldiv_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              cancel;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO registers.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : muldiv_if.slave
//            start/op/rs_data/rt_data request an operation (accepted in IDLE or DONE only),
//            cancel flushes an in-flight mul/div, busy stalls the pipeline,
//            done pulses for one cycle when HI/LO hold a new result.
// Multiplication is shift-add on operand magnitudes, division is restoring division on
// magnitudes; signs are applied in a single FIX cycle before HI/LO are written.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Shared datapath: for MUL, {acc,shreg} is the running product and operand the
    // multiplicand; for DIV, acc is the partial remainder, shreg shifts the dividend
    // out and the quotient in, operand is the divisor.
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] rs_raw;
    logic [CNT_W-1:0]  cnt;
    logic              is_div;
    logic              neg_q;      // product sign (MUL) or quotient sign (DIV)
    logic              neg_r;      // remainder sign = dividend sign
    logic              div_zero;

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              busy;
    logic              done;

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return ~v + DATA_W'(1);
    endfunction

    // ---------------- request decode ----------------
    logic              can_accept;
    logic              accept_mul;
    logic              accept_div;
    logic              op_signed;
    logic              sgn_rs;
    logic              sgn_rt;
    logic              mt_hi;
    logic              mt_lo;
    logic [DATA_W-1:0] abs_rs;
    logic [DATA_W-1:0] abs_rt;

    assign can_accept = (state == S_IDLE) || (state == S_DONE);
    assign accept_mul = can_accept && bus.start && (bus.op == OP_MULT || bus.op == OP_MULTU);
    assign accept_div = can_accept && bus.start && (bus.op == OP_DIV  || bus.op == OP_DIVU);
    assign mt_hi      = can_accept && bus.start && (bus.op == OP_MTHI);
    assign mt_lo      = can_accept && bus.start && (bus.op == OP_MTLO);
    assign op_signed  = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign sgn_rs     = op_signed && bus.rs_data[DATA_W-1];
    assign sgn_rt     = op_signed && bus.rt_data[DATA_W-1];
    // The most-negative value has magnitude 2^(DATA_W-1), which still fits unsigned.
    assign abs_rs     = sgn_rs ? negate(bus.rs_data) : bus.rs_data;
    assign abs_rt     = sgn_rt ? negate(bus.rt_data) : bus.rt_data;

    // ---------------- iteration steps ----------------
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shifted;
    logic              div_ge;
    logic [DATA_W-1:0] div_diff;

    assign mul_sum     = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
    assign div_shifted = {acc, shreg[DATA_W-1]};
    assign div_ge      = div_shifted >= {1'b0, operand};
    // The true difference is below the divisor whenever it is used, so DATA_W bits suffice.
    assign div_diff    = div_shifted[DATA_W-1:0] - operand;

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next state / outputs ----------------
    // NOTE: every signal gets a default before the case so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (accept_mul) begin
                    state_nxt = S_MUL;
                end else if (accept_div) begin
                    state_nxt = S_DIV;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                busy = 1'b1;
                if (bus.cancel) begin
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                busy      = 1'b1;
                state_nxt = bus.cancel ? S_IDLE : S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    // NOTE: operand/result storage is reset too, so nothing from an aborted operation
    // can leak into a later one after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            shreg    <= '0;
            operand  <= '0;
            rs_raw   <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept_mul || accept_div) begin
            acc      <= '0;
            operand  <= accept_div ? abs_rt : abs_rs;
            shreg    <= accept_div ? abs_rs : abs_rt;
            rs_raw   <= bus.rs_data;
            cnt      <= CNT_W'(DATA_W);
            is_div   <= accept_div;
            neg_q    <= sgn_rs ^ sgn_rt;
            neg_r    <= sgn_rs;
            div_zero <= (bus.rt_data == '0);
        end else if (state == S_MUL && !bus.cancel) begin
            acc   <= mul_sum[DATA_W:1];
            shreg <= {mul_sum[0], shreg[DATA_W-1:1]};
            cnt   <= cnt - CNT_W'(1);
        end else if (state == S_DIV && !bus.cancel) begin
            acc   <= div_ge ? div_diff : div_shifted[DATA_W-1:0];
            shreg <= {shreg[DATA_W-2:0], div_ge};
            cnt   <= cnt - CNT_W'(1);
        end
    end

    // ---------------- sign fix-up ----------------
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   hi_res;
    logic [DATA_W-1:0]   lo_res;

    always_comb begin
        prod   = {acc, shreg};
        hi_res = '0;
        lo_res = '0;
        if (is_div) begin
            if (div_zero) begin
                // Divide by zero reports the raw dividend, regardless of signedness.
                lo_res = '1;
                hi_res = rs_raw;
            end else begin
                lo_res = neg_q ? negate(shreg) : shreg;
                hi_res = neg_r ? negate(acc)   : acc;
            end
        end else begin
            if (neg_q) begin
                prod = ~prod + (2*DATA_W)'(1);
            end
            hi_res = prod[2*DATA_W-1:DATA_W];
            lo_res = prod[DATA_W-1:0];
        end
    end

    // ---------------- HI/LO ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == S_FIX && !bus.cancel) begin
            hi_q <= hi_res;
            lo_q <= lo_res;
        end else if (mt_hi) begin
            hi_q <= bus.rs_data;
        end else if (mt_lo) begin
            lo_q <= bus.rs_data;
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit. Each accepted mul/div pushes its
// hand-computed HI/LO and due cycle into a scoreboard; a monitor pops and compares on
// every done pulse.
module tb_muldiv_unit;
    localparam int W = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           due;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    muldiv_if #(.DATA_W(W)) bus ();

    muldiv_unit #(.DATA_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one request on the negedge; returns 1 time unit after the sampling edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Called right after issue(): done is due DATA_W+1 edges after the sampling edge.
    task automatic expect_result(input string name, input logic [W-1:0] hi, input logic [W-1:0] lo);
        sb.push_back('{hi, lo, cyc + W + 1, name});
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_done", {63'd0, bus.done}, 64'd1);
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo);
        issue(op, a, b);
        expect_result(name, hi, lo);
        wait_done();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every done pulse against the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset && bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", {63'd0, bus.done}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_hi"}, {32'd0, bus.hi}, {32'd0, e.hi});
                    check({e.name, "_lo"}, {32'd0, bus.lo}, {32'd0, e.lo});
                    check({e.name, "_due"}, 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cycles;
        int done_seen;

        bus.start   = 1'b0;
        bus.op      = 3'b000;
        bus.rs_data = '0;
        bus.rt_data = '0;
        bus.cancel  = 1'b0;

        // Reset state
        #12;
        check("rst_hi",   {32'd0, bus.hi}, 64'd0);
        check("rst_lo",   {32'd0, bus.lo}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // MULTU max*max with busy profile: busy in cycles 1..33, done in cycle 34
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
        busy_cycles = 0;
        for (int k = 1; k <= W + 1; k++) begin
            if (bus.busy) busy_cycles++;
            @(posedge clk);
            #1;
        end
        check("multu_busy_cycles", 64'(busy_cycles), 64'd33);
        check("multu_busy_in_done", {63'd0, bus.busy}, 64'd0);
        check("multu_done_cycle", {63'd0, bus.done}, 64'd1);
        @(posedge clk);
        #1;
        check("done_one_cycle", {63'd0, bus.done}, 64'd0);

        // Signed multiply
        run("mult_neg3x7",  OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run("mult_minxmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

        // Division, including sign rules, divide by zero and signed overflow
        run("div_neg7_2",   OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("div_7_neg2",   OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run("divu_100_7",   OP_DIVU, 32'd100,       32'd7,         32'd2,         32'd14);
        run("divu_by_zero", OP_DIVU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
        run("div_by_zero",  OP_DIV,  32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF);
        run("div_overflow", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // MTHI in IDLE: one edge, no busy/done, LO untouched
        issue(OP_MTHI, 32'h0000_1234, 32'h0);
        check("mthi_hi",   {32'd0, bus.hi}, 64'h0000_1234);
        check("mthi_lo",   {32'd0, bus.lo}, 64'h8000_0000);
        check("mthi_busy", {63'd0, bus.busy}, 64'd0);
        check("mthi_done", {63'd0, bus.done}, 64'd0);

        // MTLO and a new DIVU while busy are both ignored
        issue(OP_MULTU, 32'd2, 32'd3);
        expect_result("multu_2x3", 32'h0, 32'd6);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        issue(OP_MTLO, 32'hDEAD_BEEF, 32'h0);
        check("mtlo_busy_lo", {32'd0, bus.lo}, 64'h8000_0000);
        issue(OP_DIVU, 32'd9, 32'd3);
        check("start_busy_ignored", {63'd0, bus.busy}, 64'd1);
        wait_done();
        @(posedge clk);
        #1;

        // Back-to-back: second op accepted in the DONE cycle of the first
        issue(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
        expect_result("b2b_first", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        wait_done();
        issue(OP_MULTU, 32'd3, 32'd5);
        expect_result("b2b_second", 32'h0, 32'h0000_000F);
        check("b2b_busy", {63'd0, bus.busy}, 64'd1);
        wait_done();
        @(posedge clk);
        #1;

        // Cancel at cycle 10 of a DIVU: no done, HI/LO keep old values
        issue(OP_MTHI, 32'h0000_5A5A, 32'h0);
        issue(OP_MTLO, 32'h0000_A5A5, 32'h0);
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.cancel = 1'b1;
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        check("cancel_busy", {63'd0, bus.busy}, 64'd0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done) done_seen++;
            @(posedge clk);
            #1;
        end
        check("cancel_no_done", 64'(done_seen), 64'd0);
        check("cancel_hi", {32'd0, bus.hi}, 64'h0000_5A5A);
        check("cancel_lo", {32'd0, bus.lo}, 64'h0000_A5A5);

        // Cancel together with start in IDLE: start still accepted
        bus.cancel = 1'b1;
        issue(OP_MULTU, 32'd4, 32'd5);
        bus.cancel = 1'b0;
        expect_result("cancel_start_idle", 32'h0, 32'd20);
        wait_done();
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a MULT
        issue(OP_MTHI, 32'h0000_ABCD, 32'h0);
        check("mthi2_hi", {32'd0, bus.hi}, 64'h0000_ABCD);
        issue(OP_MULT, 32'd7, 32'd9);
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b0;
        #1;
        check("arst_hi",   {32'd0, bus.hi}, 64'd0);
        check("arst_lo",   {32'd0, bus.lo}, 64'd0);
        check("arst_busy", {63'd0, bus.busy}, 64'd0);
        check("arst_done", {63'd0, bus.done}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run("after_reset_2x3", OP_MULTU, 32'd2, 32'd3, 32'h0, 32'd6);

        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
